hazard_unit: RTL and testbench

//  Pipeline hazard controller for the 5-stage MIPS core: the producer side of the EX forwarding interface.

---
 rtl/hazard_unit.sv | 145 ++++++++++++++
 tb/tb_hazard_unit.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// Hazard controller for the 5-stage MIPS pipeline: EX/ID forwarding selects,
// stall/flush generation for load-use, branch-operand and data-memory waits,
// a memory-wait watchdog FSM and a saturating stall-cycle counter.
module hazard_unit #(
  parameter int TIMEOUT_CYCLES = 256,  // 0 disables the watchdog
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [4:0]       RsD,
  input  logic [4:0]       RtD,
  input  logic             BranchD,
  input  logic [4:0]       RsE,
  input  logic [4:0]       RtE,
  input  logic [4:0]       WriteRegE,
  input  logic             RegWriteE,
  input  logic             MemtoRegE,
  input  logic [4:0]       WriteRegM,
  input  logic             RegWriteM,
  input  logic             MemtoRegM,
  input  logic             MemAccessM,
  input  logic             MemReadyM,
  input  logic [4:0]       WriteRegW,
  input  logic             RegWriteW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushE,
  output logic             FlushW,
  output logic [CNT_W-1:0] StallCount,
  output logic             Timeout
);

  // Wait counter is at least one bit wide so a disabled watchdog still elaborates.
  localparam int              WC_W     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit              WD_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [WC_W-1:0] WC_LIMIT = WC_W'(WD_EN ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    TIMEOUT  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WC_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic lwstall;
  logic brstall;
  logic memstall;
  logic halt;
  logic ex_hits_d;
  logic mem_hits_d;

  // EX operand forwarding: MEM result wins over WB result; $0 is never forwarded.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (RsE != 5'd0 && RegWriteM && WriteRegM == RsE)      ForwardAE = 2'b10;
    else if (RsE != 5'd0 && RegWriteW && WriteRegW == RsE) ForwardAE = 2'b01;
    if (RtE != 5'd0 && RegWriteM && WriteRegM == RtE)      ForwardBE = 2'b10;
    else if (RtE != 5'd0 && RegWriteW && WriteRegW == RtE) ForwardBE = 2'b01;
  end

  assign ForwardAD = (RsD != 5'd0) && RegWriteM && (WriteRegM == RsD);
  assign ForwardBD = (RtD != 5'd0) && RegWriteM && (WriteRegM == RtD);

  // Branch comparator in ID cannot see EX results or MEM load data yet.
  assign ex_hits_d  = RegWriteE && (WriteRegE != 5'd0) &&
                      ((WriteRegE == RsD) || (WriteRegE == RtD));
  assign mem_hits_d = MemtoRegM && (WriteRegM != 5'd0) &&
                      ((WriteRegM == RsD) || (WriteRegM == RtD));

  assign lwstall  = MemtoRegE && (RtE != 5'd0) && ((RtE == RsD) || (RtE == RtD));
  assign brstall  = BranchD && (ex_hits_d || mem_hits_d);
  assign memstall = MemAccessM && !MemReadyM;
  assign halt     = (state_q == TIMEOUT);

  // Stall/flush controls; reset forces bubbles and releases every stall.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushE = 1'b1;
    FlushW = 1'b1;
    if (resetn) begin
      StallF = lwstall || brstall || memstall || halt;
      StallD = StallF;
      StallE = memstall || halt;
      StallM = StallE;
      FlushE = (lwstall || brstall) && !memstall && !halt;
      FlushW = memstall || halt;
    end
  end

  // Watchdog FSM next state: TIMEOUT absorbs until reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN, MEM_WAIT: begin
        if (memstall && WD_EN && wait_cnt_q == WC_LIMIT) state_d = TIMEOUT;
        else if (memstall)                               state_d = MEM_WAIT;
        else                                             state_d = RUN;
      end
      TIMEOUT: state_d = TIMEOUT;
      default: state_d = RUN;
    endcase
  end

  // Consecutive mem-wait counter and saturating stall-cycle counter.
  always_comb begin
    wait_cnt_d  = '0;
    stall_cnt_d = stall_cnt_q;
    if (memstall) begin
      wait_cnt_d = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + 1'b1;
    end
    if (StallF && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign StallCount = stall_cnt_q;
  assign Timeout    = (state_q == TIMEOUT);

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: a cycle model pushes expected outputs
// into a scoreboard queue when inputs are driven; they are popped and compared
// at the falling edge. A second instance runs with the watchdog disabled.
module tb_hazard_unit;

  localparam int T_MAIN = 8;

  logic       clk;
  logic       resetn;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic       BranchD, RegWriteE, MemtoRegE, RegWriteM, MemtoRegM;
  logic       MemAccessM, MemReadyM, RegWriteW;

  logic [1:0] ForwardAE, ForwardBE, n_ForwardAE, n_ForwardBE;
  logic       ForwardAD, ForwardBD, StallF, StallD, StallE, StallM, FlushE, FlushW, Timeout;
  logic       n_ForwardAD, n_ForwardBD, n_StallF, n_StallD, n_StallE, n_StallM;
  logic       n_FlushE, n_FlushW, n_Timeout;
  logic [3:0] StallCount;
  logic [7:0] n_StallCount;

  hazard_unit #(.TIMEOUT_CYCLES(T_MAIN), .CNT_W(4)) dut (
    .clk(clk), .resetn(resetn), .RsD(RsD), .RtD(RtD), .BranchD(BranchD),
    .RsE(RsE), .RtE(RtE), .WriteRegE(WriteRegE), .RegWriteE(RegWriteE),
    .MemtoRegE(MemtoRegE), .WriteRegM(WriteRegM), .RegWriteM(RegWriteM),
    .MemtoRegM(MemtoRegM), .MemAccessM(MemAccessM), .MemReadyM(MemReadyM),
    .WriteRegW(WriteRegW), .RegWriteW(RegWriteW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ForwardAD(ForwardAD),
    .ForwardBD(ForwardBD), .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .StallM(StallM), .FlushE(FlushE), .FlushW(FlushW),
    .StallCount(StallCount), .Timeout(Timeout)
  );

  hazard_unit #(.TIMEOUT_CYCLES(0), .CNT_W(8)) dut_nowd (
    .clk(clk), .resetn(resetn), .RsD(RsD), .RtD(RtD), .BranchD(BranchD),
    .RsE(RsE), .RtE(RtE), .WriteRegE(WriteRegE), .RegWriteE(RegWriteE),
    .MemtoRegE(MemtoRegE), .WriteRegM(WriteRegM), .RegWriteM(RegWriteM),
    .MemtoRegM(MemtoRegM), .MemAccessM(MemAccessM), .MemReadyM(MemReadyM),
    .WriteRegW(WriteRegW), .RegWriteW(RegWriteW),
    .ForwardAE(n_ForwardAE), .ForwardBE(n_ForwardBE), .ForwardAD(n_ForwardAD),
    .ForwardBD(n_ForwardBD), .StallF(n_StallF), .StallD(n_StallD), .StallE(n_StallE),
    .StallM(n_StallM), .FlushE(n_FlushE), .FlushW(n_FlushW),
    .StallCount(n_StallCount), .Timeout(n_Timeout)
  );

  typedef struct packed {
    logic [1:0] fae, fbe;
    logic       fad, fbd, sf, sd, se, sm, fe, fw;
    logic [7:0] cnt;
    logic       to;
  } exp_t;

  typedef struct packed {
    exp_t m;
    exp_t n;
  } pair_t;

  pair_t exp_q[$];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model state
  int m_state = 0;  // 0 RUN, 1 MEM_WAIT, 2 TIMEOUT
  int m_wait  = 0;
  int m_cnt   = 0;
  int n_cnt   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [1:0] fwd2(input logic [4:0] r);
    if (r != 0 && RegWriteM && WriteRegM == r) return 2'b10;
    if (r != 0 && RegWriteW && WriteRegW == r) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic lw_f();
    return MemtoRegE && RtE != 0 && (RtE == RsD || RtE == RtD);
  endfunction

  function automatic logic br_f();
    logic e_hit, m_hit;
    e_hit = RegWriteE && WriteRegE != 0 && (WriteRegE == RsD || WriteRegE == RtD);
    m_hit = MemtoRegM && WriteRegM != 0 && (WriteRegM == RsD || WriteRegM == RtD);
    return BranchD && (e_hit || m_hit);
  endfunction

  function automatic logic ms_f();
    return MemAccessM && !MemReadyM;
  endfunction

  function automatic exp_t model(input logic halt, input int cnt, input logic to);
    exp_t e;
    logic lw, br, ms;
    lw = lw_f(); br = br_f(); ms = ms_f();
    e.fae = fwd2(RsE);
    e.fbe = fwd2(RtE);
    e.fad = RsD != 0 && RegWriteM && WriteRegM == RsD;
    e.fbd = RtD != 0 && RegWriteM && WriteRegM == RtD;
    if (!resetn) begin
      e.sf = 0; e.sd = 0; e.se = 0; e.sm = 0; e.fe = 1; e.fw = 1;
    end else begin
      e.sf = lw | br | ms | halt;
      e.sd = e.sf;
      e.se = ms | halt;
      e.sm = e.se;
      e.fe = (lw | br) & ~ms & ~halt;
      e.fw = ms | halt;
    end
    e.cnt = 8'(cnt);
    e.to  = to;
    return e;
  endfunction

  task automatic model_update();
    logic ms, sf_m, sf_n;
    ms = ms_f();
    if (!resetn) begin
      m_state = 0; m_wait = 0; m_cnt = 0; n_cnt = 0;
    end else begin
      sf_m = lw_f() | br_f() | ms | (m_state == 2);
      sf_n = lw_f() | br_f() | ms;
      if (sf_m && m_cnt < 15) m_cnt++;
      if (sf_n && n_cnt < 255) n_cnt++;
      if (m_state != 2) begin
        if (ms && m_wait == T_MAIN - 1) m_state = 2;
        else m_state = ms ? 1 : 0;
      end
      m_wait = ms ? m_wait + 1 : 0;
    end
  endtask

  task automatic compare_out();
    pair_t p;
    if (exp_q.size() == 0) begin
      check_val("sb_empty", 32'(exp_q.size()), 1);
      return;
    end
    p = exp_q.pop_front();
    check_val("ForwardAE", ForwardAE, p.m.fae);
    check_val("ForwardBE", ForwardBE, p.m.fbe);
    check_val("ForwardAD", ForwardAD, p.m.fad);
    check_val("ForwardBD", ForwardBD, p.m.fbd);
    check_val("StallF", StallF, p.m.sf);
    check_val("StallD", StallD, p.m.sd);
    check_val("StallE", StallE, p.m.se);
    check_val("StallM", StallM, p.m.sm);
    check_val("FlushE", FlushE, p.m.fe);
    check_val("FlushW", FlushW, p.m.fw);
    check_val("StallCount", StallCount, p.m.cnt);
    check_val("Timeout", Timeout, p.m.to);
    check_val("nowd_fwd", {n_ForwardAE, n_ForwardBE, n_ForwardAD, n_ForwardBD},
              {p.n.fae, p.n.fbe, p.n.fad, p.n.fbd});
    check_val("nowd_ctl", {n_StallF, n_StallD, n_StallE, n_StallM, n_FlushE, n_FlushW},
              {p.n.sf, p.n.sd, p.n.se, p.n.sm, p.n.fe, p.n.fw});
    check_val("nowd_StallCount", n_StallCount, p.n.cnt);
    check_val("nowd_Timeout", n_Timeout, p.n.to);
    $display("txn %0d rstn=%b fae=%b fbe=%b sf=%b se=%b fe=%b fw=%b cnt=%0d to=%b",
             cyc, resetn, ForwardAE, ForwardBE, StallF, StallE, FlushE, FlushW,
             StallCount, Timeout);
  endtask

  // One clock cycle: predict, compare at negedge, advance model at posedge.
  task automatic step();
    pair_t p;
    p.m = model(m_state == 2, m_cnt, m_state == 2);
    p.n = model(1'b0, n_cnt, 1'b0);
    exp_q.push_back(p);
    @(negedge clk);
    compare_out();
    @(posedge clk);
    model_update();
    cyc++;
    #1;
  endtask

  task automatic idle_inputs();
    RsD = 0; RtD = 0; BranchD = 0; RsE = 0; RtE = 0; WriteRegE = 0;
    RegWriteE = 0; MemtoRegE = 0; WriteRegM = 0; RegWriteM = 0; MemtoRegM = 0;
    MemAccessM = 0; MemReadyM = 1; WriteRegW = 0; RegWriteW = 0;
  endtask

  task automatic do_reset();
    resetn = 0;
    step();
    resetn = 1;
  endtask

  initial begin
    resetn = 0;
    idle_inputs();
    @(posedge clk);
    #1;
    step();
    step();
    resetn = 1;

    // Forwarding: MEM beats WB; $0 never forwarded; WB-only path
    RsE = 5; RtE = 5; RegWriteM = 1; WriteRegM = 5; RegWriteW = 1; WriteRegW = 5;
    step();
    RsE = 0;
    step();
    RsE = 7; RtE = 9; WriteRegM = 9; WriteRegW = 7;
    step();
    idle_inputs();

    // Load-use: one stall cycle with EX bubble, counter +1
    do_reset();
    MemtoRegE = 1; RtE = 8; RsD = 8;
    step();
    check_val("lw_cnt", StallCount, 1);
    idle_inputs();
    step();

    // Branch operand in EX stalls; next cycle forwarded from MEM
    BranchD = 1; RsD = 3; RegWriteE = 1; WriteRegE = 3;
    step();
    RegWriteE = 0; WriteRegE = 0; RegWriteM = 1; WriteRegM = 3;
    step();
    MemtoRegM = 1; RtD = 3; RsD = 4;
    step();
    idle_inputs();

    // Memory wait of 4 cycles, with a load-use hazard on top
    do_reset();
    MemAccessM = 1; MemReadyM = 0; MemtoRegE = 1; RtE = 6; RtD = 6;
    repeat (4) step();
    MemReadyM = 1;
    MemtoRegE = 0;
    step();
    check_val("memwait_cnt", StallCount, 4);
    idle_inputs();
    step();

    // Randomised traffic with occasional reset
    repeat (80) begin
      RsD = 5'($urandom_range(0, 3)); RtD = 5'($urandom_range(0, 3));
      RsE = 5'($urandom_range(0, 3)); RtE = 5'($urandom_range(0, 3));
      WriteRegE = 5'($urandom_range(0, 3)); WriteRegM = 5'($urandom_range(0, 3));
      WriteRegW = 5'($urandom_range(0, 3));
      BranchD = 1'($urandom); RegWriteE = 1'($urandom); MemtoRegE = 1'($urandom);
      RegWriteM = 1'($urandom); MemtoRegM = 1'($urandom); RegWriteW = 1'($urandom);
      MemAccessM = 1'($urandom); MemReadyM = ($urandom_range(0, 3) != 0);
      resetn = ($urandom_range(0, 15) != 0);
      step();
    end
    idle_inputs();
    resetn = 1;

    // Watchdog: 8 consecutive waits trip TIMEOUT, sticky, then counter saturates
    do_reset();
    MemAccessM = 1; MemReadyM = 0;
    repeat (7) step();
    check_val("timeout_before", Timeout, 0);
    step();
    check_val("timeout_rise", Timeout, 1);
    MemReadyM = 1;
    repeat (10) step();
    check_val("timeout_sticky", Timeout, 1);
    check_val("cnt_saturate", StallCount, 15);
    check_val("nowd_no_timeout", n_Timeout, 0);

    // Reset while a load-use hazard is present and watchdog tripped
    MemtoRegE = 1; RtE = 8; RsD = 8; MemAccessM = 0;
    do_reset();
    check_val("rst_timeout", Timeout, 0);
    check_val("rst_cnt", StallCount, 0);
    idle_inputs();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
